// File: rtl/apb_pkg.sv
// Shared APB types: bridge FSM state encoding and the default bus widths
// used by both the bridge and the register slaves.
package apb_pkg;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared by i_load, counts while i_en is high and
// flags o_expire in the TIMEOUT-th consecutive waiting cycle. TIMEOUT=0 disables it.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt <= '0;
                end else if (i_load) begin
                    r_cnt <= '0;
                end else if (i_en && !o_expire) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Expire in the cycle that would be the TIMEOUT-th wait, so ACCESS lasts exactly TIMEOUT cycles.
            assign o_expire = i_en && (r_cnt == LAST);
        end else begin : g_tieoff
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst, i_load, i_en};
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns one valid/ready command into a SETUP+ACCESS transfer and
// returns read data / error on a valid/ready response port. One transfer in flight.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DATA_W    = APB_DATA_W,
    parameter int RDATA_DLY = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam bit RD_DLY = (RDATA_DLY != 0);

    apb_state_e        r_state;
    apb_state_e        w_next;
    logic              w_accept;
    logic              w_done;
    logic              w_timeout;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_tmr_expire;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expire (w_tmr_expire)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done     = 1'b0;
        w_timeout  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: begin
                w_tmr_load = 1'b1;
                w_next     = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    w_done = 1'b1;
                    w_next = (r_pwrite || !RD_DLY) ? RESP : RDWAIT;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_expire) begin
                        w_timeout = 1'b1;
                        w_next    = RESP;
                    end
                end
            end
            RDWAIT: begin
                w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so every port is a clean flop and reads 0 in reset.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            r_psel      <= (w_next == SETUP) || (w_next == ACCESS);
            r_penable   <= (w_next == ACCESS);

            if (w_accept) begin
                r_pwrite    <= cmd_write;
                r_paddr     <= cmd_addr;
                r_pwdata    <= cmd_write ? cmd_wdata : '0;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end

            if (w_done) begin
                r_rsp_err <= PSLVERR;
                if (!r_pwrite && !RD_DLY) begin
                    r_rsp_rdata <= PRDATA;
                end
            end

            if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end

            // Registered-read slaves present PRDATA in the cycle after the completing ACCESS.
            if (r_state == RDWAIT) begin
                r_rsp_rdata <= PRDATA;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge against a small registered-read APB
// register slave with programmable wait states, error and stuck-PREADY modes.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY;
    logic        PSLVERR;

    int tests_run = 0;
    int tests_failed = 0;

    apb_master_bridge #(
        .ADDR_W    (4),
        .DATA_W    (32),
        .RDATA_DLY (1),
        .TIMEOUT   (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: registered PRDATA, stall wait states, forced error, stuck PREADY.
    logic [31:0] regs [4] = '{32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'h5A5A_5555};
    int          stall = 0;
    int          wait_cnt = 0;
    logic        stuck = 1'b0;
    logic        force_err = 1'b0;

    assign PREADY  = !stuck && (wait_cnt >= stall);
    assign PSLVERR = force_err;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY) begin
            if (PWRITE) regs[PADDR[3:2]] <= PWDATA;
            else        PRDATA <= regs[PADDR[3:2]];
        end
        if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] res_rdata;
    logic        res_err;
    logic        res_psel;
    int          res_lat;
    int          res_acc;
    logic        res_setup_ok;
    logic        res_bus_ok;
    logic        res_hold_ok;

    // One command/response round trip. res_lat counts cycles from the accept cycle (0)
    // to the first cycle with rsp_valid; res_acc counts cycles with PSEL&PENABLE.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata, input int hold);
        int n;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge PCLK);
        cmd_valid    = 1'b0;
        res_lat      = 1;
        res_acc      = 0;
        res_setup_ok = PSEL && !PENABLE;
        res_bus_ok   = 1'b1;
        while (!rsp_valid && res_lat < 64) begin
            if (PSEL && PENABLE) res_acc++;
            if (PSEL && (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata)))
                res_bus_ok = 1'b0;
            @(negedge PCLK);
            res_lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        res_rdata   = rsp_rdata;
        res_err     = rsp_err;
        res_psel    = PSEL;
        res_hold_ok = 1'b1;
        repeat (hold) begin
            @(negedge PCLK);
            if (!rsp_valid || rsp_rdata !== res_rdata || cmd_ready || PSEL) res_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        logic no_rsp;
        int   n;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge PCLK);
        check("reset_outputs",
              {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid, rsp_rdata, rsp_err}, '0);
        PRESET = 1'b0;
        #1 check("cmd_ready_at_release", cmd_ready, 0);
        @(negedge PCLK);
        check("cmd_ready_first_cycle", cmd_ready, 1);

        // 1: read 0x4
        xfer(1'b0, 4'h4, 32'h0, 0);
        check("t1_rdata", res_rdata, 32'hA5A5_0000);
        check("t1_err", res_err, 0);
        check("t1_latency", res_lat, 4);
        check("t1_setup_first", res_setup_ok, 1);

        // 2: write then read back 0x8
        xfer(1'b1, 4'h8, 32'hDEAD_BEEF, 0);
        check("t2w_latency", res_lat, 3);
        check("t2w_rdata_zero", res_rdata, 0);
        check("t2w_err", res_err, 0);
        check("t2w_setup_first", res_setup_ok, 1);
        check("t2w_bus_stable", res_bus_ok, 1);
        check("t2w_access_cycles", res_acc, 1);
        xfer(1'b0, 4'h8, 32'h0, 0);
        check("t2r_rdata", res_rdata, 32'hDEAD_BEEF);
        check("t2r_bus_stable", res_bus_ok, 1);

        // 3: response back-pressure
        xfer(1'b0, 4'hC, 32'h0, 5);
        check("t3_hold", res_hold_ok, 1);
        check("t3_rdata", res_rdata, 32'h5A5A_5555);

        // 4: three wait states then slave error
        stall = 3;
        force_err = 1'b1;
        xfer(1'b1, 4'h0, 32'h1234_5678, 0);
        stall = 0;
        force_err = 1'b0;
        check("t4_access_cycles", res_acc, 4);
        check("t4_err", res_err, 1);
        check("t4_latency", res_lat, 6);

        // 5: PREADY stuck low -> timeout
        stuck = 1'b1;
        xfer(1'b0, 4'h4, 32'h0, 0);
        stuck = 1'b0;
        check("t5_access_cycles", res_acc, 16);
        check("t5_err", res_err, 1);
        check("t5_rdata_zero", res_rdata, 0);
        check("t5_psel_idle", res_psel, 0);
        check("t5_latency", res_lat, 18);

        // 6: reset during ACCESS
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'h4;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("t6_in_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        check("t6_psel_drop", PSEL, 0);
        check("t6_penable_drop", PENABLE, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        no_rsp = 1'b1;
        repeat (6) begin
            @(negedge PCLK);
            if (rsp_valid) no_rsp = 1'b0;
        end
        check("t6_no_response", no_rsp, 1);
        xfer(1'b0, 4'hC, 32'h0, 0);
        check("t6_rdata_after", res_rdata, 32'h5A5A_5555);
        check("t6_err_after", res_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
